// File: rtl/mul_pkg.sv
// Shared constants, stage bundle types and helpers for the
// pipelined multiplier lane beside the ALU.
package mul_pkg;

  localparam int ADDR_W_DEFAULT      = 32;
  localparam int RD_W_DEFAULT        = 5;
  localparam int MUL_LATENCY_DEFAULT = 5;
  localparam int HALF_W              = ADDR_W_DEFAULT / 2;

  typedef struct packed {
    logic                    valid;
    logic [RD_W_DEFAULT-1:0] rd;
  } stage_ctl_t;

  typedef logic [2*ADDR_W_DEFAULT-1:0] mul_payload_t;

  function automatic logic [2**RD_W_DEFAULT-1:0] rd_onehot(
    input logic [RD_W_DEFAULT-1:0] rd
  );
    logic [2**RD_W_DEFAULT-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mul_stage.sv
// One multiplier pipeline register: async clear, freeze on stall,
// bubble insertion on erase. Payload rides along with bubbles.
module mul_stage
  import mul_pkg::*;
#(
  parameter int RW = RD_W_DEFAULT,
  parameter int PW = 2 * ADDR_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          erase,
  input  logic          in_valid,
  input  logic [RW-1:0] in_rd,
  input  logic [PW-1:0] in_pay,
  output logic          out_valid,
  output logic [RW-1:0] out_rd,
  output logic [PW-1:0] out_pay
);

  logic          valid_q, valid_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [PW-1:0] pay_q, pay_d;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    pay_d   = pay_q;
    if (!stall) begin
      valid_d = in_valid && !erase;
      rd_d    = in_rd;
      pay_d   = in_pay;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      pay_q   <= pay_d;
    end
  end

  assign out_valid = valid_q;
  assign out_rd    = rd_q;
  assign out_pay   = pay_q;

endmodule

// File: rtl/mul_pipe.sv
// Fixed-latency M1..MN multiplier lane: split-half partial products,
// low-word result, in-flight destination mask for RAW stalls.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int ADDRESS_SIZE     = ADDR_W_DEFAULT,
  parameter int REG_ADDRESS_SIZE = RD_W_DEFAULT,
  parameter int LATENCY          = MUL_LATENCY_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDRESS_SIZE-1:0]       M_operand1,
  input  logic [ADDRESS_SIZE-1:0]       M_operand2,
  input  logic [REG_ADDRESS_SIZE-1:0]   M_rd,
  input  logic                          M_write,
  input  logic                          M_erase,
  input  logic                          M_stall,
  output logic [ADDRESS_SIZE-1:0]       M_result,
  output logic [REG_ADDRESS_SIZE-1:0]   M_Wat,
  output logic                          M_We,
  output logic [2**REG_ADDRESS_SIZE-1:0] M_pending,
  output logic                          M_busy
);

  localparam int W  = ADDRESS_SIZE;
  localparam int H  = W / 2;
  localparam int RW = REG_ADDRESS_SIZE;
  localparam int NR = 2 ** RW;
  localparam int PW = 2 * W;

  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0] vin;
  logic [LATENCY-1:0] er;
  logic [RW-1:0]      rd   [LATENCY];
  logic [RW-1:0]      rdin [LATENCY];
  logic [PW-1:0]      pay  [LATENCY];
  logic [PW-1:0]      nxt  [LATENCY];

  always_comb begin
    vin     = '0;
    er      = '0;
    vin[0]  = M_write;
    er[0]   = M_erase;
    rdin[0] = M_rd;
    for (int i = 1; i < LATENCY; i++) begin
      vin[i]  = v[i-1];
      rdin[i] = rd[i-1];
    end
  end

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    mul_stage #(
      .RW (RW),
      .PW (PW)
    ) u_stage (
      .clk       (clk),
      .rst       (reset),
      .stall     (M_stall),
      .erase     (er[i]),
      .in_valid  (vin[i]),
      .in_rd     (rdin[i]),
      .in_pay    (nxt[i]),
      .out_valid (v[i]),
      .out_rd    (rd[i]),
      .out_pay   (pay[i])
    );
  end

  // M1 payload is {op1, op2}; halves feed the M2 partial products
  logic [H-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [W-1:0] m2_pp0;
  logic [H-1:0] m2_pp1, m2_pp2;

  always_comb begin
    a_lo   = pay[0][W+H-1:W];
    a_hi   = pay[0][PW-1:W+H];
    b_lo   = pay[0][H-1:0];
    b_hi   = pay[0][W-1:H];
    m2_pp0 = W'(a_lo) * W'(b_lo);
    m2_pp1 = a_lo * b_hi;
    m2_pp2 = a_hi * b_lo;
  end

  // a_hi*b_hi only touches bits >= W, so it is never formed
  logic [W-1:0] s_pp0, m3_sum;
  logic [H-1:0] s_pp1, s_pp2, s_mid;

  always_comb begin
    s_pp0  = pay[1][PW-1:W];
    s_pp1  = pay[1][W-1:H];
    s_pp2  = pay[1][H-1:0];
    s_mid  = s_pp1 + s_pp2;
    m3_sum = s_pp0 + {s_mid, {H{1'b0}}};
  end

  always_comb begin
    nxt[0] = {M_operand1, M_operand2};
    nxt[1] = {m2_pp0, m2_pp1, m2_pp2};
    nxt[2] = {{W{1'b0}}, m3_sum};
    for (int i = 3; i < LATENCY; i++) begin
      nxt[i] = pay[i-1];
    end
  end

  logic unused_hi;
  assign unused_hi = ^pay[LATENCY-1][PW-1:W];

  assign M_result = pay[LATENCY-1][W-1:0];
  assign M_Wat    = rd[LATENCY-1];
  assign M_We     = v[LATENCY-1] && (rd[LATENCY-1] != '0);
  assign M_busy   = |v;

  logic [NR-1:0] pend;

  always_comb begin
    pend = '0;
    for (int s = 0; s < LATENCY; s++) begin
      if (v[s] && rd[s] != '0) begin
        pend[rd[s]] = 1'b1;
      end
    end
  end

  assign M_pending = pend;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed plus random checks of mul_pipe against an age-tracking
// list of in-flight multiplies.
module tb_mul_pipe;

  localparam int L = 5;

  logic        clk;
  logic        reset;
  logic [31:0] M_operand1, M_operand2;
  logic [4:0]  M_rd;
  logic        M_write, M_erase, M_stall;
  logic [31:0] M_result;
  logic [4:0]  M_Wat;
  logic        M_We;
  logic [31:0] M_pending;
  logic        M_busy;

  mul_pipe #(
    .ADDRESS_SIZE     (32),
    .REG_ADDRESS_SIZE (5),
    .LATENCY          (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .M_operand1 (M_operand1),
    .M_operand2 (M_operand2),
    .M_rd       (M_rd),
    .M_write    (M_write),
    .M_erase    (M_erase),
    .M_stall    (M_stall),
    .M_result   (M_result),
    .M_Wat      (M_Wat),
    .M_We       (M_We),
    .M_pending  (M_pending),
    .M_busy     (M_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          age;
    logic [4:0]  rd;
    logic [31:0] p;
  } op_t;

  op_t q[$];
  int  nvec = 0;
  int  nerr = 0;
  int  nwe  = 0;

  task automatic model_edge(input logic w, input logic e,
                            input logic s, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] r);
    op_t n;
    op_t keep[$];
    if (reset) begin
      q.delete();
      return;
    end
    if (s) return;
    keep.delete();
    foreach (q[i]) begin
      n = q[i];
      n.age++;
      if (n.age < L) keep.push_back(n);
    end
    q = keep;
    if (w && !e) begin
      n.age = 0;
      n.rd  = r;
      n.p   = a * b;
      q.push_back(n);
    end
  endtask

  task automatic check(input string tag);
    logic        ewe, ebusy, have;
    logic [31:0] epend, eres;
    logic [4:0]  erd;
    ewe = 0; have = 0; epend = '0; eres = '0; erd = '0;
    ebusy = (q.size() != 0);
    foreach (q[i]) begin
      if (q[i].rd != 0) epend[q[i].rd] = 1'b1;
      if (q[i].age == L - 1) begin
        have = 1;
        erd  = q[i].rd;
        eres = q[i].p;
        ewe  = (q[i].rd != 0);
      end
    end
    if (M_We === 1'b1) nwe++;
    nvec++;
    assert (M_We === ewe) else begin
      nerr++;
      $error("FAIL %s we obs=%b exp=%b", tag, M_We, ewe);
    end
    nvec++;
    assert (M_pending === epend) else begin
      nerr++;
      $error("FAIL %s pend obs=%h exp=%h", tag, M_pending, epend);
    end
    nvec++;
    assert (M_busy === ebusy) else begin
      nerr++;
      $error("FAIL %s busy obs=%b exp=%b", tag, M_busy, ebusy);
    end
    if (have) begin
      nvec++;
      assert (M_result === eres) else begin
        nerr++;
        $error("FAIL %s res obs=%h exp=%h", tag, M_result, eres);
      end
      nvec++;
      assert (M_Wat === erd) else begin
        nerr++;
        $error("FAIL %s wat obs=%0d exp=%0d", tag, M_Wat, erd);
      end
    end
  endtask

  task automatic cyc(input string tag, input logic w, input logic e,
                     input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] r);
    M_write = w; M_erase = e; M_stall = s;
    M_operand1 = a; M_operand2 = b; M_rd = r;
    @(posedge clk);
    model_edge(w, e, s, a, b, r);
    @(negedge clk);
    M_write = 0; M_erase = 0; M_stall = 0;
    check(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int we0;
    reset = 1; M_write = 0; M_erase = 0; M_stall = 0;
    M_operand1 = 0; M_operand2 = 0; M_rd = 0;
    @(posedge clk);
    model_edge(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 0;
    check("rst");
    nvec++;
    assert (M_result === 32'h0 && M_Wat === 5'd0) else begin
      nerr++;
      $error("FAIL rst_out obs=%h/%0d exp=0/0", M_result, M_Wat);
    end

    we0 = nwe;
    cyc("single", 1, 0, 0, 3, 7, 4);
    idle("single", 7);
    nvec++;
    assert (nwe - we0 == 1) else begin
      nerr++;
      $error("FAIL single_cnt obs=%0d exp=1", nwe - we0);
    end

    cyc("b2b", 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    cyc("b2b", 1, 0, 0, 32'h00010000, 32'h00010000, 2);
    cyc("b2b", 1, 0, 0, 32'h12345678, 32'h9ABCDEF0, 3);
    idle("b2b", 7);

    we0 = nwe;
    cyc("stall", 1, 0, 0, 5, 6, 7);
    idle("stall", 2);
    cyc("stall", 0, 0, 1, 0, 0, 0);
    cyc("stall", 1, 1, 1, 9, 9, 8);
    cyc("stall", 1, 0, 1, 9, 9, 8);
    idle("stall", 7);
    nvec++;
    assert (nwe - we0 == 1) else begin
      nerr++;
      $error("FAIL stall_cnt obs=%0d exp=1", nwe - we0);
    end

    cyc("erase", 1, 1, 0, 11, 12, 9);
    idle("erase", 6);

    cyc("r0", 1, 0, 0, 2, 2, 0);
    idle("r0", 6);

    cyc("arst", 1, 0, 0, 100, 3, 10);
    cyc("arst", 1, 0, 0, 7, 8, 11);
    #2 reset = 1;
    #1 q.delete();
    check("arst_now");
    cyc("arst", 1, 0, 0, 1, 1, 12);
    reset = 0;
    cyc("post", 1, 0, 0, 4, 4, 5);
    idle("post", 6);

    for (int i = 0; i < 300; i++) begin
      cyc("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0, $urandom, $urandom,
          5'($urandom_range(0, 31)));
    end
    idle("drain", 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
Fixed-latency pipelined integer multiplier that runs as the M1..M5 lane beside the ALU.
- Consumes operand and destination bundles from the DM decode stage.
- Delivers the low 32 bits of the product, with destination and write-enable, to the register-file writeback mux.
- Exposes an in-flight destination mask so DM can stall on RAW hazards against pending multiplies.

Parameters:
ADDRESS_SIZE, 32, data/operand width (must be even; halves used for partial products)
REG_ADDRESS_SIZE, 5, register index width
LATENCY, 5, number of pipeline stages M1..MN from capture to writeback; legal range 3..8

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high; clears all stage state
M_operand1  input  ADDRESS_SIZE  multiplicand from DM
M_operand2  input  ADDRESS_SIZE  multiplier from DM
M_rd  input  REG_ADDRESS_SIZE  destination register
M_write  input  1  valid multiply issued this cycle
M_erase  input  1  load a bubble into M1 instead of the input bundle (flush/DM stall)
M_stall  input  1  freeze every stage (writeback port busy)
M_result  output  ADDRESS_SIZE  product low word at stage MN
M_Wat  output  REG_ADDRESS_SIZE  destination at stage MN
M_We  output  1  writeback enable at stage MN
M_pending  output  2**REG_ADDRESS_SIZE  one-hot OR of destinations of all valid in-flight stages
M_busy  output  1  any stage valid

Behaviour:
- Stage record per stage: valid, rd, and datapath payload. Stages advance together on clk when M_stall=0.
- Reset (async, any time, including mid-operation): all valid=0 and all payload=0. Outputs become M_result=0, M_Wat=0, M_We=0, M_pending=0, M_busy=0.
- M1 capture, when M_stall=0:
  - M_erase=1 -> valid=0.
  - Otherwise valid=M_write, with rd and operands captured.
- M_stall=1: every stage holds its contents, including M1. The input bundle is dropped, and M_erase has no effect that cycle; upstream must hold and re-present.
- Arithmetic: let h=ADDRESS_SIZE/2.
  - M1 registers a_lo, a_hi, b_lo, b_hi.
  - M2 registers pp0=a_lo*b_lo (2h bits), pp1=a_lo*b_hi and pp2=a_hi*b_lo, each truncated to h bits.
  - M3 registers sum = pp0 + ((pp1+pp2) << h), truncated to ADDRESS_SIZE.
  - M4..MN are pass-through registers.
  - Result is the low ADDRESS_SIZE bits of op1*op2, identical for signed and unsigned. The high word is not produced.
- Latency: a valid issued at edge k (captured into M1) appears on M_We/M_result/M_Wat after edge k+LATENCY-1, i.e. visible during cycle k+LATENCY-1, assuming no stall. Each stall cycle adds exactly one cycle.
- Throughput: one multiply per cycle, so back-to-back issues retire on consecutive cycles in order.
- Outputs M_result/M_Wat/M_We are driven directly from stage MN registers; no combinational path from inputs.
- M_We = MN.valid && (MN.rd != 0). Writes to r0 retire silently.
- M_pending:
  - Bit r is set iff some stage s in M1..MN has valid && rd==r && r!=0.
  - Combinational from stage registers only.
  - Includes MN, so DM sees the hazard until writeback completes.
- M_busy = OR of all stage valids.
- Bubbles (valid=0) carry payload but never assert M_We or M_pending.
- Simultaneous stall + erase: stall wins, nothing changes. Simultaneous reset with anything: reset wins.

Decomposition:
- Package mul_pkg holds:
  - constants MUL_LATENCY_DEFAULT and HALF_W;
  - typedef stage_ctl_t {valid, rd};
  - typedef mul_payload_t, a union-sized vector of ADDRESS_SIZE*2 bits reused per stage;
  - function rd_onehot(rd).
- One sub-module, mul_stage: a generic stage register with async reset, stall hold, and bubble-on-erase. It is instantiated LATENCY times via generate. Arithmetic lives between instances in mul_pipe.

Test Plan:
- Reset, then issue op1=3, op2=7, rd=4, single pulse -> 4 cycles later M_We=1, M_Wat=4, M_result=21, for exactly one cycle; M_pending[4]=1 from the cycle after issue through the M_We cycle, then 0.
- Issue 0xFFFFFFFF*0xFFFFFFFF rd=1, then 0x00010000*0x00010000 rd=2, then 0x12345678*0x9ABCDEF0 rd=3, on consecutive cycles -> results 0x00000001, 0x00000000, 0x242D2080 retire on three consecutive cycles, in order.
- Issue 5*6 rd=7, assert M_stall for 3 cycles while the op is in M3 -> all stage contents frozen; M_We occurs 3 cycles late with result 30; no duplicate writeback.
- Issue with M_write=1 and M_erase=1 (rd=9) -> no M_We ever; M_pending[9] never set; M_busy stays 0.
- Issue rd=0, 2*2 -> M_We stays 0, M_pending stays 0, M_busy=1 for 5 cycles.
- Issue two ops, assert reset asynchronously mid-cycle while both are in flight -> M_We, M_pending and M_busy drop to 0 immediately, with no clock edge needed; after release, a new op 4*4 rd=5 retires normally with 16.
